// File: rtl/bmp_scan_if.sv
// Bitmap scan bus: load handshake, bitmap register strobes/address/read data,
// and the downstream row offer handshake.
interface bmp_scan_if #(
  parameter int ROW_W = 24,
  parameter int AW    = 6
);
  logic             load_valid;
  logic             load_ready;
  logic             bmp_wren;
  logic             bmp_rden;
  logic [AW-1:0]    bmp_addr;
  logic [ROW_W-1:0] row_in;
  logic             row_valid;
  logic [ROW_W-1:0] row_data;
  logic [AW-1:0]    row_idx;
  logic             row_ready;

  modport master (
    input  load_valid, row_in, row_ready,
    output load_ready, bmp_wren, bmp_rden, bmp_addr, row_valid, row_data, row_idx
  );

  modport slave (
    output load_valid, row_in, row_ready,
    input  load_ready, bmp_wren, bmp_rden, bmp_addr, row_valid, row_data, row_idx
  );
endinterface

// File: rtl/bmp_scan_ctrl.sv
// Loads a bitmap into the bitmap register, then reads it back row by row,
// offering each row downstream and counting rows with any bit set.
module bmp_scan_ctrl #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 24,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  bmp_scan_if.master    bus,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   nz_count
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, PRESENT, DONE} state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] row_cnt;
  logic          handshake;

  assign handshake = (state == PRESENT) && bus.row_valid && bus.row_ready && !abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort overrides every transition and suppresses the strobes of that cycle.
  always_comb begin
    state_nxt      = state;
    bus.load_ready = 1'b0;
    bus.bmp_wren   = 1'b0;
    bus.bmp_rden   = 1'b0;
    bus.bmp_addr   = '0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (bus.load_valid) begin
          bus.bmp_wren = 1'b1;
          state_nxt    = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          bus.bmp_rden = 1'b1;
          bus.bmp_addr = row_cnt;
          state_nxt    = PRESENT;
        end
      end
      PRESENT: begin
        if (abort)          state_nxt = IDLE;
        else if (handshake) state_nxt = (row_cnt == LAST_ROW) ? DONE : READ;
      end
      DONE: begin
        done      = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row read data is sampled on the edge that ends the READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt       <= '0;
      nz_count      <= '0;
      bus.row_valid <= 1'b0;
      bus.row_data  <= '0;
      bus.row_idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        row_cnt  <= '0;
        nz_count <= '0;
      end
      if (state == READ && !abort) begin
        bus.row_data  <= bus.row_in;
        bus.row_idx   <= row_cnt;
        bus.row_valid <= 1'b1;
      end
      if (handshake) begin
        bus.row_valid <= 1'b0;
        nz_count      <= nz_count + {{AW{1'b0}}, |bus.row_data};
        if (row_cnt != LAST_ROW) row_cnt <= row_cnt + 1'b1;
      end
      if (abort && state != IDLE) bus.row_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// Randomized bench for bmp_scan_ctrl: a bitmap register model plus a
// behavioural scoreboard of loads, reads, row handshakes and done pulses.
module tb_bmp_scan_ctrl;
  localparam int ROWS  = 64;
  localparam int ROW_W = 24;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [AW:0]   nz_count;

  bmp_scan_if #(.ROW_W(ROW_W), .AW(AW)) bus ();

  bmp_scan_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .nz_count (nz_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [ROW_W-1:0] src [ROWS];
  logic [ROW_W-1:0] mem [ROWS];

  // Bitmap register: whole-bitmap write, read data valid while rden is high.
  always @(posedge clk)
    if (bus.bmp_wren)
      for (int i = 0; i < ROWS; i++) mem[i] <= src[i];

  always_comb bus.row_in = bus.bmp_rden ? mem[bus.bmp_addr] : 24'h5a5a5a;

  // Scoreboard observations, sampled mid-cycle.
  int cyc, wren_cnt, done_cnt, accept_cyc, done_cyc;
  int stab_err, excl_err, rden_valid_err, watch_row, watch_cnt;
  int rd_addr [$];
  int hs_idx [$];
  logic [ROW_W-1:0] hs_data [$];
  logic pv;
  logic [AW-1:0] pidx;
  logic [ROW_W-1:0] pdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      cyc++;
      if (bus.bmp_wren) begin wren_cnt++; accept_cyc = cyc; end
      if (bus.bmp_rden) rd_addr.push_back(int'(bus.bmp_addr));
      if ((bus.bmp_wren && bus.bmp_rden) || ((!busy || done) && (bus.bmp_wren || bus.bmp_rden)))
        excl_err++;
      if (bus.bmp_rden && bus.row_valid) rden_valid_err++;
      if (pv && !(bus.row_valid && bus.row_idx == pidx && bus.row_data == pdata)) stab_err++;
      if (bus.row_valid && bus.row_ready && !abort) begin
        hs_idx.push_back(int'(bus.row_idx));
        hs_data.push_back(bus.row_data);
      end
      if (bus.row_valid && int'(bus.row_idx) == watch_row) watch_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      pv    = bus.row_valid && !bus.row_ready && !abort;
      pidx  = bus.row_idx;
      pdata = bus.row_data;
    end
  end

  task automatic clear_mon();
    cyc = 0; wren_cnt = 0; done_cnt = 0; accept_cyc = -1000; done_cyc = 0;
    stab_err = 0; excl_err = 0; rden_valid_err = 0; watch_row = -1; watch_cnt = 0;
    rd_addr.delete(); hs_idx.delete(); hs_data.delete();
  endtask

  // mode 0: random with ~1/4 zero rows, 1: all zero, 2: all ones, 3: only rows 3 and 40 set
  task automatic make_bitmap(input int mode);
    for (int i = 0; i < ROWS; i++) begin
      case (mode)
        0: src[i] = ($urandom_range(0, 3) == 0) ? '0 : ROW_W'($urandom);
        1: src[i] = '0;
        2: src[i] = '1;
        default: src[i] = (i == 3 || i == 40) ? (ROW_W'($urandom) | 24'h1) : '0;
      endcase
    end
  endtask

  function automatic int count_nz(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (src[i] != '0) c++;
    return c;
  endfunction

  function automatic int hs_errors(input int n);
    int bad = 0;
    if (hs_idx.size() != n) bad++;
    for (int i = 0; i < hs_idx.size() && i < n; i++)
      if (hs_idx[i] != i || hs_data[i] != src[i]) bad++;
    return bad;
  endfunction

  // status: 0 = done seen, 1 = busy dropped without done, 2 = cycle budget expired
  task automatic run_job(input int ready_mode, input int stall_row, input int stall_len,
                         input int abort_row, input bit busy_start, output int status);
    int stall_left;
    stall_left = stall_len;
    status = 2;
    bus.load_valid = 1'b1;
    bus.row_ready  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin status = 0; break; end
      if (!busy) begin status = 1; break; end
      bus.row_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.row_valid && int'(bus.row_idx) == stall_row && stall_left > 0) begin
        bus.row_ready = 1'b0;
        stall_left--;
      end
      if (bus.row_valid && int'(bus.row_idx) == abort_row) begin
        abort = 1'b1;
        bus.row_ready = 1'b1;
      end
      if (busy_start) start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
    bus.row_ready  = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, bus.load_ready, bus.bmp_wren, bus.bmp_rden, bus.row_valid} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {busy, done, bus.load_ready, bus.bmp_wren, bus.bmp_rden, bus.row_valid});
    if ({busy, done, bus.load_ready, bus.bmp_wren, bus.bmp_rden, bus.row_valid} !== 6'b0) failures++;
    checks++;
    if ({bus.row_data, bus.row_idx, bus.bmp_addr, nz_count} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: row_data=%h row_idx=%0d addr=%0d nz=%0d want all 0",
               bus.row_data, bus.row_idx, bus.bmp_addr, nz_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_scan();
    int status, bad;
    clear_mon();
    make_bitmap(3);
    run_job(0, -1, 0, -1, 1'b0, status);
    checks++;
    if (status !== 0) begin failures++; $display("[TB] FAIL scan_status: got %0d want 0", status); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wren_cnt !== 1) begin failures++; $display("[TB] FAIL scan_wren: got %0d want 1", wren_cnt); end
    bad = (rd_addr.size() != ROWS) ? 1 : 0;
    for (int i = 0; i < rd_addr.size() && i < ROWS; i++) if (rd_addr[i] != i) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL scan_rden_addrs: %0d pulses, %0d bad, want 64 at 0..63", rd_addr.size(), bad);
    end
    checks++;
    if (hs_errors(ROWS) !== 0) begin
      failures++;
      $display("[TB] FAIL scan_handshakes: %0d handshakes, %0d bad, want 64 correct", hs_idx.size(), hs_errors(ROWS));
    end
    checks++;
    if (done_cyc - accept_cyc !== 129) begin
      failures++;
      $display("[TB] FAIL scan_latency: got %0d want 129", done_cyc - accept_cyc);
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("[TB] FAIL scan_done: got %0d want 1", done_cnt); end
    checks++;
    if (nz_count !== (AW+1)'(2)) begin failures++; $display("[TB] FAIL scan_nz: got %0d want 2", nz_count); end
    checks++;
    if (excl_err !== 0) begin failures++; $display("[TB] FAIL strobe_excl: got %0d violations want 0", excl_err); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy, nz_count} !== {1'b0, (AW+1)'(2)}) begin
      failures++;
      $display("[TB] FAIL nz_hold: busy=%b nz=%0d want busy=0 nz=2", busy, nz_count);
    end
  endtask

  task automatic test_stall();
    int status;
    clear_mon();
    make_bitmap(0);
    watch_row = 7;
    run_job(1, 7, 5, -1, 1'b0, status);
    @(posedge clk); #1;
    checks++;
    if (watch_cnt < 6) begin failures++; $display("[TB] FAIL stall_len: row7 offered %0d cycles want >=6", watch_cnt); end
    checks++;
    if (stab_err !== 0) begin failures++; $display("[TB] FAIL stall_stable: got %0d changes want 0", stab_err); end
    checks++;
    if (rden_valid_err !== 0) begin failures++; $display("[TB] FAIL stall_rden: got %0d want 0", rden_valid_err); end
    checks++;
    if (hs_errors(ROWS) !== 0) begin failures++; $display("[TB] FAIL stall_handshakes: got %0d bad want 0", hs_errors(ROWS)); end
    checks++;
    if ({done_cnt, 32'(nz_count)} !== {32'd1, 32'(count_nz(ROWS))}) begin
      failures++;
      $display("[TB] FAIL stall_result: done=%0d nz=%0d want done=1 nz=%0d", done_cnt, nz_count, count_nz(ROWS));
    end
  endtask

  task automatic test_abort();
    int status;
    clear_mon();
    make_bitmap(0);
    src[10] = 24'hffffff;
    run_job(1, -1, 0, 10, 1'b0, status);
    checks++;
    if ({busy, bus.row_valid, done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL abort_idle: busy=%b row_valid=%b done=%b want 000", busy, bus.row_valid, done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d want 0", done_cnt); end
    checks++;
    if (nz_count !== (AW+1)'(count_nz(10))) begin
      failures++;
      $display("[TB] FAIL abort_nz: got %0d want %0d", nz_count, count_nz(10));
    end
    checks++;
    if (hs_errors(10) !== 0) begin failures++; $display("[TB] FAIL abort_handshakes: got %0d handshakes want 10", hs_idx.size()); end
  endtask

  task automatic test_start_while_busy();
    int status;
    clear_mon();
    make_bitmap(0);
    run_job(1, -1, 0, -1, 1'b1, status);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done_cnt, wren_cnt} !== {32'd1, 32'd1}) begin
      failures++;
      $display("[TB] FAIL busy_start_once: done=%0d wren=%0d want 1 1", done_cnt, wren_cnt);
    end
    checks++;
    if (hs_errors(ROWS) !== 0 || nz_count !== (AW+1)'(count_nz(ROWS))) begin
      failures++;
      $display("[TB] FAIL busy_start_scan: bad=%0d nz=%0d want bad=0 nz=%0d", hs_errors(ROWS), nz_count, count_nz(ROWS));
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int status;
    bit found;
    clear_mon();
    make_bitmap(0);
    found = 1'b0;
    bus.load_valid = 1'b1;
    bus.row_ready  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.bmp_rden && bus.bmp_addr == AW'(20)) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL rst_reach_read: row 20 read not seen within 200 cycles"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.load_ready, bus.bmp_wren, bus.bmp_rden, bus.row_valid,
         bus.row_data, bus.row_idx, bus.bmp_addr, nz_count} !== '0) begin
      failures++;
      $display("[TB] FAIL rst_async: busy=%b rden=%b valid=%b data=%h idx=%0d addr=%0d nz=%0d want all 0",
               busy, bus.bmp_rden, bus.row_valid, bus.row_data, bus.row_idx, bus.bmp_addr, nz_count);
    end
    bus.load_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (done_cnt !== 0) begin failures++; $display("[TB] FAIL rst_no_done: got %0d want 0", done_cnt); end
    @(posedge clk); #1;
    clear_mon();
    make_bitmap(0);
    run_job(0, -1, 0, -1, 1'b0, status);
    @(posedge clk); #1;
    checks++;
    if ({32'(status), done_cnt, 32'(hs_errors(ROWS))} !== {32'd0, 32'd1, 32'd0}) begin
      failures++;
      $display("[TB] FAIL rst_rescan: status=%0d done=%0d bad=%0d want 0 1 0", status, done_cnt, hs_errors(ROWS));
    end
    checks++;
    if (nz_count !== (AW+1)'(count_nz(ROWS))) begin
      failures++;
      $display("[TB] FAIL rst_rescan_nz: got %0d want %0d", nz_count, count_nz(ROWS));
    end
  endtask

  task automatic test_zero_ones();
    int status;
    clear_mon();
    make_bitmap(1);
    run_job(1, -1, 0, -1, 1'b0, status);
    @(posedge clk); #1;
    checks++;
    if ({done_cnt, 32'(nz_count)} !== {32'd1, 32'd0}) begin
      failures++;
      $display("[TB] FAIL zeros: done=%0d nz=%0d want 1 0", done_cnt, nz_count);
    end
    clear_mon();
    make_bitmap(2);
    run_job(0, -1, 0, -1, 1'b0, status);
    @(posedge clk); #1;
    checks++;
    if ({done_cnt, 32'(nz_count)} !== {32'd1, 32'd64}) begin
      failures++;
      $display("[TB] FAIL ones: done=%0d nz=%0d want 1 64", done_cnt, nz_count);
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.row_ready  = 1'b0;
    clear_mon();
    for (int i = 0; i < ROWS; i++) src[i] = '0;
    test_reset();
    test_full_scan();
    test_stall();
    test_abort();
    test_start_while_busy();
    test_reset_mid_read();
    test_zero_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
